// File: rtl/ni_rx_sram_writer_if.sv
// Flit-in / SRAM-out bundle for the NI receive writer.
// The writer uses the slave side. The flit source and SRAM sink use the master side.
interface ni_rx_sram_writer_if;
  logic [47:0] flit_in;
  logic        flit_valid;
  logic        flit_ready;
  logic        sram_we;
  logic [7:0]  sram_addr;
  logic [15:0] sram_data_out;
  logic [7:0]  src_addr;
  logic        packet_end;
  logic        packet_err;

  modport slave (
    input  flit_in, flit_valid,
    output flit_ready, sram_we, sram_addr, sram_data_out, src_addr, packet_end, packet_err
  );

  modport master (
    output flit_in, flit_valid,
    input  flit_ready, sram_we, sram_addr, sram_data_out, src_addr, packet_end, packet_err
  );
endinterface

// File: rtl/ni_rx_sram_writer.sv
// Receives head/body/tail flits addressed to this node and writes the body words to SRAM.
// The tail checksum is verified, and a one-cycle end or error pulse reports the outcome.
//
// state | meaning
// IDLE  | waiting for a head flit; other flits are consumed silently
// BODY  | writing body words; the tail closes the packet
// DROP  | discarding flits until a tail arrives
// STAT  | one-cycle status slot in which the end/err pulse is visible; not ready
module ni_rx_sram_writer #(
  parameter logic [7:0] NODE_ADDR = 8'h00,
  parameter logic [7:0] SRAM_BASE = 8'h00,
  parameter int         MAX_LEN   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  ni_rx_sram_writer_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BODY = 2'd1,
    S_DROP = 2'd2,
    S_STAT = 2'd3
  } state_t;

  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_BODY = 2'b10;
  localparam logic [1:0] T_TAIL = 2'b11;
  localparam logic [7:0] LP_MAX_LEN = 8'(MAX_LEN);

  state_t      r_state, w_state_n;
  logic [7:0]  r_cnt, w_cnt_n;
  logic [7:0]  r_len, w_len_n;
  logic [15:0] r_acc, w_acc_n;
  logic        r_err, w_err_n;
  logic [7:0]  r_src, w_src_n;
  logic        r_we, w_we_n;
  logic [7:0]  r_addr, w_addr_n;
  logic [15:0] r_data, w_data_n;
  logic        r_end, w_end_n;
  logic        r_perr, w_perr_n;

  logic        w_ready;
  logic        w_xfer;
  logic [1:0]  w_type;
  logic [7:0]  w_hd_src;
  logic [7:0]  w_hd_dest;
  logic [7:0]  w_hd_len;
  logic [15:0] w_word;

  assign w_ready   = !reset && (r_state != S_STAT);
  assign w_xfer    = bus.flit_valid && w_ready;
  assign w_type    = bus.flit_in[47:46];
  assign w_hd_src  = bus.flit_in[45:38];
  assign w_hd_dest = bus.flit_in[37:30];
  assign w_hd_len  = bus.flit_in[29:22];
  assign w_word    = bus.flit_in[15:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
      r_acc   <= '0;
      r_err   <= 1'b0;
      r_src   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_end   <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_len   <= w_len_n;
      r_acc   <= w_acc_n;
      r_err   <= w_err_n;
      r_src   <= w_src_n;
      r_we    <= w_we_n;
      r_addr  <= w_addr_n;
      r_data  <= w_data_n;
      r_end   <= w_end_n;
      r_perr  <= w_perr_n;
    end
  end

  // The status pulse is registered on the tail itself.
  // It therefore coincides with the STAT cycle, one cycle after the tail.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_len_n   = r_len;
    w_acc_n   = r_acc;
    w_err_n   = r_err;
    w_src_n   = r_src;
    w_we_n    = 1'b0;
    w_addr_n  = r_addr;
    w_data_n  = r_data;
    w_end_n   = 1'b0;
    w_perr_n  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_xfer && (w_type == T_HEAD)) begin
          if (w_hd_dest != NODE_ADDR) begin
            w_state_n = S_DROP;
          end else if (w_hd_len > LP_MAX_LEN) begin
            w_err_n   = 1'b1;
            w_state_n = S_DROP;
          end else begin
            w_src_n   = w_hd_src;
            w_len_n   = w_hd_len;
            w_cnt_n   = '0;
            w_acc_n   = '0;
            w_state_n = S_BODY;
          end
        end
      end

      S_BODY: begin
        if (w_xfer) begin
          case (w_type)
            T_BODY: begin
              if (r_cnt < r_len) begin
                w_we_n   = 1'b1;
                w_addr_n = SRAM_BASE + r_cnt;
                w_data_n = w_word;
                w_cnt_n  = r_cnt + 8'd1;
                w_acc_n  = r_acc ^ w_word;
              end else begin
                w_err_n   = 1'b1;
                w_state_n = S_DROP;
              end
            end
            T_TAIL: begin
              if ((r_cnt != r_len) || (w_word != r_acc)) begin
                w_err_n  = 1'b1;
                w_perr_n = 1'b1;
              end else begin
                w_end_n  = 1'b1;
              end
              w_state_n = S_STAT;
            end
            default: begin
              w_err_n   = 1'b1;
              w_state_n = S_DROP;
            end
          endcase
        end
      end

      S_DROP: begin
        if (w_xfer && (w_type == T_TAIL)) begin
          if (r_err) begin
            w_perr_n  = 1'b1;
            w_state_n = S_STAT;
          end else begin
            w_state_n = S_IDLE;
          end
        end
      end

      S_STAT: begin
        w_err_n   = 1'b0;
        w_state_n = S_IDLE;
      end

      default: w_state_n = S_IDLE;
    endcase
  end

  assign bus.flit_ready    = w_ready;
  assign bus.sram_we       = r_we;
  assign bus.sram_addr     = r_addr;
  assign bus.sram_data_out = r_data;
  assign bus.src_addr      = r_src;
  assign bus.packet_end    = r_end;
  assign bus.packet_err    = r_perr;

endmodule

// File: tb/tb_ni_rx_sram_writer.sv
// Directed bench for ni_rx_sram_writer.
// The node address is 8'h3A, the SRAM base is 8'hFE so addresses wrap, and MAX_LEN is 4.
module tb_ni_rx_sram_writer;
  localparam logic [7:0] NODE = 8'h3A;
  localparam logic [7:0] BASE = 8'hFE;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   n_we = 0, n_end = 0, n_err = 0, n_both = 0, n_rdy_bad = 0;

  ni_rx_sram_writer_if ifc ();

  ni_rx_sram_writer #(.NODE_ADDR(NODE), .SRAM_BASE(BASE), .MAX_LEN(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ifc.sram_we) n_we++;
    if (ifc.packet_end) n_end++;
    if (ifc.packet_err) n_err++;
    if (ifc.packet_end && ifc.packet_err) n_both++;
    if (!reset && !ifc.flit_ready && !(ifc.packet_end || ifc.packet_err)) n_rdy_bad++;
  end

  function automatic logic [47:0] head(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
    return {2'b01, s, d, l, 22'h0};
  endfunction
  function automatic logic [47:0] body(input logic [15:0] w);
    return {2'b10, 30'h0, w};
  endfunction
  function automatic logic [47:0] tail(input logic [15:0] w);
    return {2'b11, 30'h0, w};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds the flit until it is accepted.
  // On return, the outputs show the result of that flit.
  task automatic send(input logic [47:0] f);
    logic rdy;
    int   n;
    ifc.flit_in    = f;
    ifc.flit_valid = 1'b1;
    n = 0;
    do begin
      rdy = ifc.flit_ready;
      step();
      n++;
    end while (!rdy && n < 20);
    ifc.flit_valid = 1'b0;
    if (!rdy) begin
      checks++;
      errors++;
      $error("FAIL send_timeout: observed=not_ready expected=ready");
    end
  endtask

  int we0, end0, err0;
  task automatic mark();
    we0 = n_we; end0 = n_end; err0 = n_err;
  endtask

  initial begin
    ifc.flit_in    = '0;
    ifc.flit_valid = 1'b0;

    // reset
    step(); step();
    chk("rst_ready", 32'(ifc.flit_ready), 0);
    chk("rst_we", 32'(ifc.sram_we), 0);
    chk("rst_addr", 32'(ifc.sram_addr), 0);
    chk("rst_data", 32'(ifc.sram_data_out), 0);
    chk("rst_src", 32'(ifc.src_addr), 0);
    chk("rst_pulses", 32'({ifc.packet_end, ifc.packet_err}), 0);
    reset = 1'b0;
    #1;
    chk("rdy_after_rst", 32'(ifc.flit_ready), 1);

    // good packet; the third write wraps to address 0
    mark();
    send(head(8'h05, NODE, 8'd3));
    chk("good_head_we", 32'(ifc.sram_we), 0);
    send(body(16'h1111));
    chk("good_b0", 32'({ifc.sram_we, ifc.sram_addr, ifc.sram_data_out}), {7'h0, 1'b1, 8'hFE, 16'h1111});
    send(body(16'h2222));
    chk("good_b1", 32'({ifc.sram_we, ifc.sram_addr, ifc.sram_data_out}), {7'h0, 1'b1, 8'hFF, 16'h2222});
    send(body(16'h4444));
    chk("good_b2", 32'({ifc.sram_we, ifc.sram_addr, ifc.sram_data_out}), {7'h0, 1'b1, 8'h00, 16'h4444});
    send(tail(16'h7777));
    chk("good_tail_pulses", 32'({ifc.packet_end, ifc.packet_err}), 32'h2);
    chk("good_tail_we", 32'(ifc.sram_we), 0);
    chk("stat_not_ready", 32'(ifc.flit_ready), 0);
    chk("good_src", 32'(ifc.src_addr), 32'h05);
    step();
    chk("after_stat", 32'({ifc.flit_ready, ifc.packet_end, ifc.packet_err}), 32'h4);
    chk("hold_addr_data", 32'({ifc.sram_addr, ifc.sram_data_out}), 32'h004444);
    chk("good_counts", 32'({8'(n_we - we0), 8'(n_end - end0), 8'(n_err - err0)}), 32'h030100);

    // checksum error
    mark();
    send(head(8'h05, NODE, 8'd3));
    send(body(16'h1111));
    send(body(16'h2222));
    send(body(16'h4444));
    send(tail(16'h7776));
    chk("csum_pulses", 32'({ifc.packet_end, ifc.packet_err}), 32'h1);
    step();
    chk("csum_counts", 32'({8'(n_we - we0), 8'(n_end - end0), 8'(n_err - err0)}), 32'h030001);

    // foreign packet: dropped silently, and the tail returns straight to IDLE
    mark();
    send(head(8'h09, NODE + 8'd1, 8'd2));
    send(body(16'hAAAA));
    send(body(16'h5555));
    send(tail(16'hFFFF));
    chk("foreign_ready", 32'(ifc.flit_ready), 1);
    step();
    chk("foreign_counts", 32'({8'(n_we - we0), 8'(n_end - end0), 8'(n_err - err0)}), 32'h0);

    // short packet: len 2 with only one body
    mark();
    send(head(8'h01, NODE, 8'd2));
    send(body(16'h0ABC));
    send(tail(16'h0ABC));
    chk("short_pulses", 32'({ifc.packet_end, ifc.packet_err}), 32'h1);
    step();
    chk("short_counts", 32'({8'(n_we - we0), 8'(n_end - end0), 8'(n_err - err0)}), 32'h010001);

    // overrun: len 1 with two bodies
    mark();
    send(head(8'h02, NODE, 8'd1));
    send(body(16'h1234));
    chk("ovr_b0", 32'({ifc.sram_we, ifc.sram_addr}), 32'h1FE);
    send(body(16'h5678));
    chk("ovr_b1_we", 32'(ifc.sram_we), 0);
    send(tail(16'h1234));
    chk("ovr_pulses", 32'({ifc.packet_end, ifc.packet_err}), 32'h1);
    step();
    chk("ovr_counts", 32'({8'(n_we - we0), 8'(n_end - end0), 8'(n_err - err0)}), 32'h010001);

    // length above MAX_LEN, then a head in BODY, then junk in IDLE
    mark();
    send(head(8'h03, NODE, 8'd5));
    send(body(16'h0001));
    send(tail(16'h0001));
    chk("toolong_pulses", 32'({ifc.packet_end, ifc.packet_err}), 32'h1);
    send(head(8'h04, NODE, 8'd2));
    send(body(16'h0002));
    send(head(8'h04, NODE, 8'd0));
    send(tail(16'h0002));
    chk("headinbody_pulses", 32'({ifc.packet_end, ifc.packet_err}), 32'h1);
    send(body(16'h0003));
    send(tail(16'h0000));
    send(48'h0);
    step();
    chk("err_junk_counts", 32'({8'(n_we - we0), 8'(n_end - end0), 8'(n_err - err0)}), 32'h010002);

    // back-pressure and gaps with len-0 packets
    mark();
    n_rdy_bad = 0;
    for (int p = 0; p < 6; p++) begin
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
        ifc.flit_in = 48'({$urandom(), $urandom()});
        step();
      end
      send(head(8'(8'h10 + p), NODE, 8'd0));
      for (int g = int'($urandom_range(0, 1)); g > 0; g--) step();
      send(tail(16'h0000));
    end
    step();
    chk("bp_counts", 32'({8'(n_we - we0), 8'(n_end - end0), 8'(n_err - err0)}), 32'h000600);
    chk("bp_ready_only_stat", 32'(n_rdy_bad), 0);
    chk("bp_src", 32'(ifc.src_addr), 32'h15);

    // mid-packet reset
    mark();
    send(head(8'h77, NODE, 8'd4));
    send(body(16'hBEEF));
    send(body(16'hCAFE));
    reset = 1'b1;
    #1;
    chk("midrst_ready", 32'(ifc.flit_ready), 0);
    step();
    chk("midrst_outs", 32'({ifc.sram_we, ifc.sram_addr, ifc.sram_data_out}), 0);
    chk("midrst_src_pulses", 32'({ifc.src_addr, ifc.packet_end, ifc.packet_err}), 0);
    reset = 1'b0;
    #1;
    we0 = n_we; end0 = n_end; err0 = n_err;
    send(body(16'h0001));
    send(body(16'h0002));
    send(tail(16'h0003));
    step();
    chk("midrst_counts", 32'({8'(n_we - we0), 8'(n_end - end0), 8'(n_err - err0)}), 32'h0);
    send(head(8'h66, NODE, 8'd0));
    send(tail(16'h0000));
    chk("post_rst_good", 32'({ifc.packet_end, ifc.packet_err}), 32'h2);
    step();
    chk("never_both", 32'(n_both), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
